// File: rtl/cpu_bus_responder_pkg.sv
// Shared definitions for the CPU bus responder: address regions, DMA constants,
// DMA state encoding and the address decoder.
package cpu_bus_responder_pkg;

   localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
   localparam logic [2:0]  OAMDATA_IDX  = 3'd4;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_PPU,
      REG_IO,
      REG_PRG,
      REG_OPEN
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DMA_ALIGN,
      ST_DMA_READ,
      ST_DMA_WRITE
   } dma_state_e;

   // Read-data hold: RAM data comes from the RAM's own output register, others are captured here
   typedef struct packed {
      region_e    src;
      logic [7:0] data;
   } rd_hold_t;

   // $4014 decodes as open bus; its write side is caught separately as the DMA trigger
   function automatic region_e decode_region(input logic [15:0] addr);
      if (addr[15])
         return REG_PRG;
      if (addr[15:13] == 3'b000)
         return REG_RAM;
      if (addr[15:13] == 3'b001)
         return REG_PPU;
      if ((addr[15:5] == 11'h200) && (addr != DMA_REG_ADDR))
         return REG_IO;
      return REG_OPEN;
   endfunction

endpackage

// File: rtl/cpu_bus_responder_ram.sv
// Internal work RAM: single port, synchronous read and write.
module cpu_work_ram #(
   parameter int unsigned RAM_AW = 11
) (
   input  logic              clk,
   input  logic [RAM_AW-1:0] addr,
   input  logic [7:0]        wdata,
   input  logic              we,
   input  logic              re,
   output logic [7:0]        rdata
);

   localparam int unsigned DEPTH = 1 << RAM_AW;

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      else if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU memory-bus target: decodes RAM/PPU/IO/PRG/open-bus accesses and runs OAM DMA
// from a CPU page into PPU OAMDATA while halting the CPU.
module cpu_bus_responder
   import cpu_bus_responder_pkg::*;
#(
   parameter int unsigned RAM_AW         = 11,
   parameter int unsigned PRG_AW         = 15,
   parameter int unsigned DMA_PAGE_BYTES = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       cpu_addr,
   input  logic [7:0]        cpu_wdata,
   input  logic              cpu_write_en,
   input  logic              cpu_read_en,
   output logic [7:0]        cpu_rdata,
   output logic              halt,
   output logic [2:0]        ppu_addr,
   output logic [7:0]        ppu_wdata,
   output logic              ppu_we,
   output logic              ppu_re,
   input  logic [7:0]        ppu_rdata,
   output logic [4:0]        io_addr,
   output logic [7:0]        io_wdata,
   output logic              io_we,
   output logic              io_re,
   input  logic [7:0]        io_rdata,
   output logic [PRG_AW-1:0] prg_addr,
   input  logic [7:0]        prg_rdata
);

   localparam logic [7:0] LAST_IDX = 8'(DMA_PAGE_BYTES - 1);

   dma_state_e state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   rd_hold_t   hold_q, hold_d;

   logic [15:0] act_addr;
   region_e     region;
   logic        cpu_rd_cyc, cpu_wr_cyc, rd_cyc;
   logic        ram_we, ram_re;
   logic [7:0]  ram_q;

   // DMA borrows the normal decode/read path with its own source address
   assign act_addr   = (state_q == ST_IDLE) ? cpu_addr : {page_q, idx_q};
   assign region     = decode_region(act_addr);
   assign cpu_rd_cyc = (state_q == ST_IDLE) && !cpu_write_en;
   assign cpu_wr_cyc = (state_q == ST_IDLE) && cpu_write_en;
   assign rd_cyc     = cpu_rd_cyc || (state_q == ST_DMA_READ);

   // Holds the last read result or CPU write data; doubles as the open-bus latch
   assign cpu_rdata = (hold_q.src == REG_RAM) ? ram_q : hold_q.data;

   cpu_work_ram #(
      .RAM_AW (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .addr  (act_addr[RAM_AW-1:0]),
      .wdata (cpu_wdata),
      .we    (ram_we),
      .re    (ram_re),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         page_q  <= 8'h00;
         idx_q   <= 8'h00;
         hold_q  <= '{src: REG_OPEN, data: 8'h00};
         halt    <= 1'b0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         halt    <= (state_d != ST_IDLE);
      end
   end

   always_comb begin
      state_d   = state_q;
      page_d    = page_q;
      idx_d     = idx_q;
      hold_d    = hold_q;
      ppu_addr  = act_addr[2:0];
      ppu_wdata = cpu_wdata;
      ppu_we    = cpu_wr_cyc && (region == REG_PPU);
      ppu_re    = cpu_rd_cyc && cpu_read_en && (region == REG_PPU);
      io_addr   = act_addr[4:0];
      io_wdata  = cpu_wdata;
      io_we     = cpu_wr_cyc && (region == REG_IO);
      io_re     = cpu_rd_cyc && cpu_read_en && (region == REG_IO);
      prg_addr  = act_addr[PRG_AW-1:0];
      ram_we    = cpu_wr_cyc && (region == REG_RAM);
      ram_re    = rd_cyc && (region == REG_RAM);

      if (rd_cyc) begin
         case (region)
            REG_RAM: hold_d.src = REG_RAM;
            REG_PPU: hold_d = '{src: REG_PPU, data: ppu_rdata};
            REG_IO:  hold_d = '{src: REG_IO,  data: io_rdata};
            REG_PRG: hold_d = '{src: REG_PRG, data: prg_rdata};
            default: hold_d = '{src: REG_OPEN, data: cpu_rdata};
         endcase
      end else if (cpu_wr_cyc) begin
         hold_d = '{src: REG_OPEN, data: cpu_wdata};
      end

      case (state_q)
         ST_IDLE: begin
            if (cpu_wr_cyc && (cpu_addr == DMA_REG_ADDR)) begin
               page_d  = cpu_wdata;
               state_d = ST_DMA_ALIGN;
            end
         end
         ST_DMA_ALIGN: begin
            idx_d   = 8'h00;
            state_d = ST_DMA_READ;
         end
         ST_DMA_READ: state_d = ST_DMA_WRITE;
         ST_DMA_WRITE: begin
            // The byte read last cycle is now on cpu_rdata
            ppu_addr  = OAMDATA_IDX;
            ppu_wdata = cpu_rdata;
            ppu_we    = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = ST_DMA_READ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!rst) begin
         ppu_addr  = 3'd0;
         ppu_wdata = 8'h00;
         ppu_we    = 1'b0;
         ppu_re    = 1'b0;
         io_addr   = 5'd0;
         io_wdata  = 8'h00;
         io_we     = 1'b0;
         io_re     = 1'b0;
         prg_addr  = '0;
         ram_we    = 1'b0;
         ram_re    = 1'b0;
      end
   end

endmodule
